// File: rtl/display_owner_arbiter_if.sv
// Request/grant bundle between the function-code sources and the display owner arbiter.
// master drives function codes and arbitration controls; slave is the arbiter.
interface display_owner_arbiter_if #(
  parameter int N_IF   = 2,
  parameter int FUNC_W = 3
);
  localparam int IDXW = (N_IF > 1) ? $clog2(N_IF) : 1;

  logic [N_IF*FUNC_W-1:0] func_in;
  logic [N_IF-1:0]        en_in;
  logic                   mode;
  logic [IDXW-1:0]        prio_sel;
  logic [N_IF-1:0]        grant_oh;
  logic [IDXW-1:0]        grant_idx;
  logic                   grant_valid;
  logic                   switch_pulse;

  modport master (
    output func_in, en_in, mode, prio_sel,
    input  grant_oh, grant_idx, grant_valid, switch_pulse
  );

  modport slave (
    input  func_in, en_in, mode, prio_sel,
    output grant_oh, grant_idx, grant_valid, switch_pulse
  );
endinterface

// File: rtl/display_owner_arbiter.sv
// Picks one display owner among interfaces running the display function, with
// fixed/rotatable priority or round robin, minimum hold tenure and registered one-hot grant.
module display_owner_req_lane #(
  parameter int                FUNC_W    = 3,
  parameter logic [FUNC_W-1:0] DISP_FUNC = 3'b010
) (
  input  logic [FUNC_W-1:0] func_i,
  input  logic              en_i,
  output logic              req_o
);
  assign req_o = en_i & (func_i == DISP_FUNC);
endmodule

module display_owner_arbiter #(
  parameter int                N_IF      = 2,
  parameter int                FUNC_W    = 3,
  parameter logic [FUNC_W-1:0] DISP_FUNC = 3'b010,
  parameter int                HOLD_CYC  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_owner_arbiter_if.slave   bus
);
  localparam int IDXW = (N_IF > 1) ? $clog2(N_IF) : 1;
  localparam int HW   = $clog2(HOLD_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;

  logic [N_IF-1:0] req;

  for (genvar g = 0; g < N_IF; g++) begin : g_lane
    display_owner_req_lane #(.FUNC_W(FUNC_W), .DISP_FUNC(DISP_FUNC)) u_lane (
      .func_i (bus.func_in[g*FUNC_W +: FUNC_W]),
      .en_i   (bus.en_in[g]),
      .req_o  (req[g])
    );
  end

  logic [1:0]      state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [IDXW-1:0] owner_q, owner_d, last_q, last_d;
  logic [N_IF-1:0] goh_q, goh_d;
  logic            sw_q, sw_d;
  logic [IDXW-1:0] fx_win, rr_win, win;
  logic            any_req, owner_req, take;

  // Fixed order starts at prio_sel; descending scan lets the lowest offset win.
  always_comb begin : fx_search
    int base, idx;
    fx_win = '0;
    base   = (int'(bus.prio_sel) >= N_IF) ? 0 : int'(bus.prio_sel);
    for (int k = N_IF-1; k >= 0; k--) begin
      idx = base + k;
      if (idx >= N_IF) idx = idx - N_IF;
      if (req[idx[IDXW-1:0]]) fx_win = IDXW'(idx);
    end
  end

  // Round robin starts after last owner; offset N_IF is the last owner itself.
  always_comb begin : rr_search
    int ridx;
    rr_win = '0;
    for (int k = N_IF; k >= 1; k--) begin
      ridx = int'(last_q) + k;
      if (ridx >= N_IF) ridx = ridx - N_IF;
      if (req[ridx[IDXW-1:0]]) rr_win = IDXW'(ridx);
    end
  end

  assign any_req   = |req;
  assign win       = bus.mode ? rr_win : fx_win;
  assign owner_req = req[owner_q];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    last_d  = last_q;
    goh_d   = goh_q;
    sw_d    = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: take = any_req;
      default: begin
        if (!owner_req) begin
          if (any_req) begin
            take = 1'b1;
            sw_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
            owner_d = '0;
            goh_d   = '0;
          end
        end else if (state_q == ST_LOCKED) begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) state_d = ST_OPEN;
        end else if (win != owner_q) begin
          // Owner still requesting: winner differs only if it outranks the owner.
          take = 1'b1;
          sw_d = 1'b1;
        end
      end
    endcase
    if (take) begin
      owner_d    = win;
      last_d     = win;
      goh_d      = '0;
      goh_d[win] = 1'b1;
      hold_d     = HW'(HOLD_CYC - 1);
      state_d    = (HOLD_CYC == 1) ? ST_OPEN : ST_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      owner_q <= '0;
      last_q  <= IDXW'(N_IF - 1);
      goh_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      goh_q   <= goh_d;
      sw_q    <= sw_d;
    end
  end

  assign bus.grant_oh     = goh_q;
  assign bus.grant_idx    = owner_q;
  assign bus.grant_valid  = (state_q != ST_IDLE);
  assign bus.switch_pulse = sw_q;
endmodule

// File: tb/tb_display_owner_arbiter.sv
// Bench for display_owner_arbiter: directed scenarios on a 2-interface/hold-4 and a
// 4-interface/hold-1 instance, then random traffic against a tenure-based reference model.
module tb_display_owner_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  display_owner_arbiter_if #(.N_IF(2), .FUNC_W(3)) if2 ();
  display_owner_arbiter_if #(.N_IF(4), .FUNC_W(3)) if4 ();

  display_owner_arbiter #(.N_IF(2), .FUNC_W(3), .DISP_FUNC(3'b010), .HOLD_CYC(4)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));
  display_owner_arbiter #(.N_IF(4), .FUNC_W(3), .DISP_FUNC(3'b010), .HOLD_CYC(1)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));

  // {grant_oh, grant_idx, grant_valid, switch_pulse}
  logic [4:0] obs2;
  logic [7:0] obs4;
  assign obs2 = {if2.grant_oh, if2.grant_idx, if2.grant_valid, if2.switch_pulse};
  assign obs4 = {if4.grant_oh, if4.grant_idx, if4.grant_valid, if4.switch_pulse};

  // Reference model: owner index (-1 = none), cycles of tenure so far, last owner.
  int m_owner[2], m_ten[2], m_last[2];
  bit m_sw[2];

  function automatic int first_req(int n, bit [7:0] r, int start);
    for (int k = 0; k < n; k++)
      if (r[(start + k) % n]) return (start + k) % n;
    return -1;
  endfunction

  task automatic model_reset(input int d, input int n);
    m_owner[d] = -1; m_ten[d] = 0; m_last[d] = n - 1; m_sw[d] = 0;
  endtask

  task automatic model_grant(input int d, input int w, input bit sw);
    m_owner[d] = w; m_last[d] = w; m_ten[d] = 1; m_sw[d] = sw;
  endtask

  task automatic model_step(input int d, input int n, input int hold, input bit [7:0] r,
                            input bit mode, input int prio);
    int p, o, w, start;
    p = (prio >= n) ? 0 : prio;
    o = m_owner[d];
    m_sw[d] = 0;
    start = mode ? (m_last[d] + 1) % n : p;
    if (o < 0) begin
      w = first_req(n, r, start);
      if (w >= 0) model_grant(d, w, 0);
    end else if (!r[o]) begin
      w = first_req(n, r, start);
      if (w >= 0) model_grant(d, w, 1);
      else begin m_owner[d] = -1; m_ten[d] = 0; end
    end else if (m_ten[d] < hold) begin
      m_ten[d]++;
    end else if (mode) begin
      if ((r & ~(8'b1 << o)) != 8'b0)
        model_grant(d, first_req(n, r & ~(8'b1 << o), (o + 1) % n), 1);
    end else begin
      w = -1;
      for (int i = 0; i < n; i++)
        if (r[i] && ((i - p + n) % n) < ((o - p + n) % n) &&
            (w < 0 || ((i - p + n) % n) < ((w - p + n) % n))) w = i;
      if (w >= 0) model_grant(d, w, 1);
    end
  endtask

  task automatic drive2(input bit [1:0] en, input bit [2:0] f1, input bit [2:0] f0,
                        input bit mode, input bit prio);
    if2.en_in = en; if2.func_in = {f1, f0}; if2.mode = mode; if2.prio_sel = prio;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset(0, 2);
    model_reset(1, 4);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b0);
    if4.en_in = '0; if4.func_in = '0; if4.mode = 1'b0; if4.prio_sel = '0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs2 !== 5'b0) begin n_errors++; $display("FAIL reset_u2 got %b want %b", obs2, 5'b0); end
    n_checks++;
    if (obs4 !== 8'b0) begin n_errors++; $display("FAIL reset_u4 got %b want %b", obs4, 8'b0); end
    do_reset();
  endtask

  task automatic test_fixed_prio();
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b0);
    do_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b01010) begin n_errors++; $display("FAIL prio0_first got %b want %b", obs2, 5'b01010); end
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b1);
    do_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b10110) begin n_errors++; $display("FAIL prio1_first got %b want %b", obs2, 5'b10110); end
    drive2(2'b11, 3'b010, 3'b011, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs2 !== 5'b10110) begin n_errors++; $display("FAIL prio1_nonreq cyc %0d got %b want %b", k, obs2, 5'b10110); end
    end
  endtask

  task automatic test_hold();
    drive2(2'b10, 3'b010, 3'b010, 1'b0, 1'b0);
    do_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b10110) begin n_errors++; $display("FAIL hold_k got %b want %b", obs2, 5'b10110); end
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs2 !== 5'b10110) begin n_errors++; $display("FAIL hold_k+%0d got %b want %b", k, obs2, 5'b10110); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b01011) begin n_errors++; $display("FAIL hold_switch got %b want %b", obs2, 5'b01011); end
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b01010) begin n_errors++; $display("FAIL hold_pulse_end got %b want %b", obs2, 5'b01010); end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    if4.en_in = 4'b1111; if4.func_in = {4{3'b010}}; if4.mode = 1'b1; if4.prio_sel = 2'd2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = {4'(1 << (i % 4)), 2'(i % 4), 1'b1, (i > 0)};
      n_checks++;
      if (obs4 !== e) begin n_errors++; $display("FAIL rr_seq %0d got %b want %b", i, obs4, e); end
    end
  endtask

  task automatic test_owner_drop();
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b0);
    do_reset();
    @(posedge clk); #1;
    drive2(2'b10, 3'b010, 3'b010, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b10111) begin n_errors++; $display("FAIL drop_handover got %b want %b", obs2, 5'b10111); end
    drive2(2'b01, 3'b010, 3'b010, 1'b0, 1'b0);
    do_reset();
    @(posedge clk); #1;
    drive2(2'b00, 3'b010, 3'b010, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b00000) begin n_errors++; $display("FAIL drop_idle got %b want %b", obs2, 5'b00000); end
    drive2(2'b11, 3'b010, 3'b110, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive2(2'b11, 3'b100, 3'b010, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b01011) begin n_errors++; $display("FAIL drop_func got %b want %b", obs2, 5'b01011); end
  endtask

  task automatic test_async_reset();
    drive2(2'b11, 3'b010, 3'b010, 1'b0, 1'b0);
    do_reset();
    @(posedge clk); #1;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs2 !== 5'b00000) begin n_errors++; $display("FAIL async_clear got %b want %b", obs2, 5'b00000); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (obs2 !== 5'b01010) begin n_errors++; $display("FAIL async_restart got %b want %b", obs2, 5'b01010); end
  endtask

  task automatic test_random();
    bit [2:0] f2 [2];
    bit [2:0] f4 [4];
    bit [1:0] en2;
    bit [3:0] en4;
    bit       md2, md4, pr2;
    bit [1:0] pr4;
    bit [7:0] r2, r4;
    logic [4:0] e2;
    logic [7:0] e4;
    for (int i = 0; i < 2; i++) f2[i] = 3'b010;
    for (int i = 0; i < 4; i++) f4[i] = 3'b010;
    en2 = '1; en4 = '1; md2 = 0; md4 = 1; pr2 = 0; pr4 = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) do_reset();
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 3) == 0) begin
          en2[i] = ($urandom_range(0, 3) != 0);
          f2[i]  = ($urandom_range(0, 2) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
        end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) begin
          en4[i] = ($urandom_range(0, 3) != 0);
          f4[i]  = ($urandom_range(0, 2) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
        end
      if ($urandom_range(0, 19) == 0) md2 = ~md2;
      if ($urandom_range(0, 19) == 0) md4 = ~md4;
      if ($urandom_range(0, 19) == 0) pr2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) pr4 = 2'($urandom_range(0, 3));
      drive2(en2, f2[1], f2[0], md2, pr2);
      if4.en_in = en4; if4.func_in = {f4[3], f4[2], f4[1], f4[0]};
      if4.mode = md4; if4.prio_sel = pr4;
      r2 = '0; r4 = '0;
      for (int i = 0; i < 2; i++) r2[i] = en2[i] && (f2[i] == 3'b010);
      for (int i = 0; i < 4; i++) r4[i] = en4[i] && (f4[i] == 3'b010);
      model_step(0, 2, 4, r2, md2, int'(pr2));
      model_step(1, 4, 1, r4, md4, int'(pr4));
      @(posedge clk); #1;
      e2 = '0; e4 = '0;
      if (m_owner[0] >= 0) e2 = {2'(1 << m_owner[0]), 1'(m_owner[0]), 1'b1, 1'b0};
      if (m_owner[1] >= 0) e4 = {4'(1 << m_owner[1]), 2'(m_owner[1]), 1'b1, 1'b0};
      e2[0] = m_sw[0];
      e4[0] = m_sw[1];
      n_checks++;
      if (obs2 !== e2) begin n_errors++; $display("FAIL rand_u2 cyc %0d got %b want %b", c, obs2, e2); end
      n_checks++;
      if (obs4 !== e4) begin n_errors++; $display("FAIL rand_u4 cyc %0d got %b want %b", c, obs4, e4); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_hold();
    test_round_robin();
    test_owner_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/display_owner_arbiter.md
Name: display_owner_arbiter

Overview:
- Registered, parametrised successor to the two-interface 7-segment display selector.
- Up to N_IF input interfaces each present a function code; every interface currently executing the display function (DISP_FUNC) requests the display.
- The block grants display ownership to exactly one requester, by fixed priority (rotatable via prio_sel) or round robin.
- Minimum-hold protection and a one-hot owner output drive the 7-segment mux downstream.

Parameters:
N_IF, 2, number of input interfaces (2..8)
FUNC_W, 3, function-code width per interface
DISP_FUNC, 3'b010, function code that requests the display (function 2)
HOLD_CYC, 4, minimum ownership tenure in cycles (>=1)
IDXW (localparam), max(1,clog2(N_IF)), owner index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
func_in  in  N_IF*FUNC_W  function codes; interface i at bits [i*FUNC_W +: FUNC_W]; interface 0 = IE01
en_in  in  N_IF  interface i active; func_in slice ignored when 0
mode  in  1  0 = fixed priority, 1 = round robin
prio_sel  in  IDXW  fixed mode: highest-priority interface index
grant_oh  out  N_IF  one-hot owner, all-zero when no owner
grant_idx  out  IDXW  owner index, 0 when no owner
grant_valid  out  1  an owner exists
switch_pulse  out  1  one-cycle strobe on owner-to-owner handover

Behaviour:
- Interface: one clock (clk); reset rst_n asynchronous, active-low.
- Reset (async assert, sync-edge release):
  - grant_oh=0, grant_idx=0, grant_valid=0, switch_pulse=0.
  - state IDLE, hold_cnt=0, last_owner=N_IF-1, so the first round-robin search starts at 0.
- Request: req[i] = en_in[i] & (func_in slice i == DISP_FUNC). Combinational; all outputs registered; req-to-grant latency 1 cycle.
- Fixed priority order: prio_sel, prio_sel+1, ... mod N_IF.
  - prio_sel >= N_IF is treated as 0.
  - N_IF=2, prio_sel=0 gives IE01 priority; prio_sel=1 gives IE02 priority.
- Round-robin order: last_owner+1, last_owner+2, ... mod N_IF.
- mode and prio_sel are sampled every cycle; a change affects the next decision only and never forces a switch by itself.
- States: IDLE (no owner), LOCKED (owner, hold_cnt!=0), OPEN (owner, hold_cnt==0).
- IDLE:
  - If any req: grant winner, set last_owner, load hold_cnt=HOLD_CYC-1, go to LOCKED (OPEN if HOLD_CYC==1). switch_pulse stays 0.
  - Otherwise remain in IDLE.
- LOCKED, owner still requesting: no switch. Decrement hold_cnt; go to OPEN when it reaches 0. Owner tenure is exactly HOLD_CYC cycles minimum.
- OPEN, owner still requesting:
  - Fixed mode: switch only if a requester exists above the owner in priority order.
  - RR mode: switch if any other requester exists; choose the next in RR order after the owner.
  - Otherwise hold the grant indefinitely.
- Owner stops requesting, in LOCKED or OPEN (func change or en_in drop): hold is waived.
  - Other requesters present: next edge grants the arbitration winner among them (mode order), switch_pulse=1.
  - None: next edge goes to IDLE, grant cleared.
- Every switch:
  - reloads hold_cnt and updates last_owner;
  - switch_pulse high exactly 1 cycle;
  - grant_oh never has two bits set and never passes through zero.
- Simultaneous new requests in IDLE are resolved purely by the current mode order.
- Reset mid-ownership: outputs clear immediately on rst_n fall, without a clock edge. After release, arbitration restarts from IDLE with last_owner=N_IF-1.

Test Plan:
1. N_IF=2, mode=0, prio_sel=0, both func=3'b010, en=2'b11, release reset -> first edge: grant_oh=2'b01, grant_idx=0, grant_valid=1, switch_pulse=0.
2. Same with prio_sel=1 -> grant_oh=2'b10, grant_idx=1. Then func_in IE01=3'b011 -> grant unchanged; no request from IE01.
3. HOLD_CYC=4, mode=0, prio_sel=0: IE02 alone granted at edge k; IE01 requests at k+1 -> grant stays 2'b10 through cycle k+3; edge k+4: grant_oh=2'b01, switch_pulse=1 for one cycle.
4. N_IF=4, HOLD_CYC=1, mode=1, all requesting -> grant_idx sequence 0,1,2,3,0 on consecutive cycles; switch_pulse high from second grant on.
5. HOLD_CYC=4, owner IE01 drops en_in at cycle 1 of tenure while IE02 requests -> next edge grant_oh=2'b10, switch_pulse=1. If IE02 is not requesting instead -> grant_valid=0, grant_oh=0.
6. Owner granted, pull rst_n low between edges -> grant_oh, grant_valid and switch_pulse read 0 before the next clk edge. After release, case 1 reproduces exactly.
